// File: rtl/leg_pkg.sv
// Shared writeback-path constants and the result record carried from functional units to the CDB.
package leg_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned TAG_W  = 7;
   localparam int unsigned REG_AW = 5;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_result_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: per-source result handshakes in, register-file write port and CDB broadcast out.
interface wb_arbiter_if #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned TAG_W   = leg_pkg::TAG_W,
   parameter int unsigned XLEN    = leg_pkg::XLEN
);
   import leg_pkg::*;

   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*TAG_W-1:0]  src_tag;
   logic [NUM_SRC*REG_AW-1:0] src_rd;
   logic [NUM_SRC*XLEN-1:0]   src_data;

   logic                      rf_we;
   logic [REG_AW-1:0]         rf_wa;
   logic [XLEN-1:0]           rf_wd;
   logic                      cdb_valid;
   logic [TAG_W-1:0]          cdb_tag;
   logic [XLEN-1:0]           cdb_data;

   modport master (
      output src_valid, src_tag, src_rd, src_data,
      input  src_ready, rf_we, rf_wa, rf_wd, cdb_valid, cdb_tag, cdb_data
   );

   modport slave (
      input  src_valid, src_tag, src_rd, src_data,
      output src_ready, rf_we, rf_wa, rf_wd, cdb_valid, cdb_tag, cdb_data
   );

endinterface

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]                     i_req,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_ptr,
   output logic [N-1:0]                     o_gnt,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_idx,
   output logic                             o_any
);
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   always_comb begin
      int unsigned w_j;
      w_j   = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[w_j]) begin
            o_gnt[w_j] = 1'b1;
            o_idx      = IW'(w_j);
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one round-robin grant per cycle, registered onto the RF write port and CDB.
// Build option WB_LOAD_PRIO_EN gives source 0 (load unit) fixed top priority.
module wb_arbiter
   import leg_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned TAG_W   = leg_pkg::TAG_W,
   parameter int unsigned XLEN    = leg_pkg::XLEN
) (
   input logic         clk,
   input logic         reset,
   wb_arbiter_if.slave bus
);
   localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [PW-1:0]      r_ptr;
   logic [PW-1:0]      w_ptr_nxt;
   logic [NUM_SRC-1:0] w_req;
   logic [NUM_SRC-1:0] w_rr_gnt;
   logic [NUM_SRC-1:0] w_gnt;
   logic [PW-1:0]      w_rr_idx;
   logic [PW-1:0]      w_idx;
   logic               w_rr_any;
   logic               w_any;
   logic               w_ptr_upd;

   logic               r_valid;
   logic [TAG_W-1:0]   r_tag;
   logic [REG_AW-1:0]  r_rd;
   logic [XLEN-1:0]    r_data;
   logic               w_out_valid;

`ifdef WB_LOAD_PRIO_EN
   // Source 0 is served outside the rotation, so hide it from the round-robin picker.
   assign w_req = {bus.src_valid[NUM_SRC-1:1], 1'b0};
`else
   assign w_req = bus.src_valid;
`endif

   rr_arbiter #(
      .N(NUM_SRC)
   ) u_rr (
      .i_req (w_req),
      .i_ptr (r_ptr),
      .o_gnt (w_rr_gnt),
      .o_idx (w_rr_idx),
      .o_any (w_rr_any)
   );

   always_comb begin
      w_gnt     = w_rr_gnt;
      w_idx     = w_rr_idx;
      w_any     = w_rr_any;
      w_ptr_upd = w_rr_any;
`ifdef WB_LOAD_PRIO_EN
      if (bus.src_valid[0]) begin
         w_gnt     = {{(NUM_SRC-1){1'b0}}, 1'b1};
         w_idx     = '0;
         w_any     = 1'b1;
         w_ptr_upd = 1'b0;
      end
`endif
   end

   assign w_ptr_nxt     = (w_idx == PW'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;
   assign bus.src_ready = reset ? '0 : w_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_rd    <= '0;
         r_data  <= '0;
      end else begin
         if (w_ptr_upd) r_ptr <= w_ptr_nxt;
         r_valid <= w_any;
         if (w_any) begin
            r_tag  <= bus.src_tag[w_idx*TAG_W +: TAG_W];
            r_rd   <= bus.src_rd[w_idx*REG_AW +: REG_AW];
            r_data <= bus.src_data[w_idx*XLEN +: XLEN];
         end
      end
   end

   // A result still held when reset rises must not reach the RF or the reservation stations.
   assign w_out_valid   = r_valid & ~reset;
   assign bus.cdb_valid = w_out_valid;
   assign bus.cdb_tag   = r_tag;
   assign bus.cdb_data  = r_data;
   assign bus.rf_we     = w_out_valid && (r_rd != '0);
   assign bus.rf_wa     = r_rd;
   assign bus.rf_wd     = r_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner cases, randomized model check.
module tb_wb_arbiter;
   import leg_pkg::*;

`ifdef WB_LOAD_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [3:0]  in_valid;
   logic [6:0]  in_tag[4];
   logic [4:0]  in_rd[4];
   logic [31:0] in_data[4];

   int         m_ptr;
   logic       m_valid;
   wb_result_t m_res;

   wb_arbiter_if #(.NUM_SRC(4), .TAG_W(7), .XLEN(32)) bus ();

   wb_arbiter #(.NUM_SRC(4), .TAG_W(7), .XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rule: first valid source scanning ptr, ptr+1, ... modulo 4.
   function automatic int model_pick(input logic [3:0] v, input int ptr);
      if (PRIO && v[0]) return 0;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (ptr + k) % 4;
         if (v[i] && !(PRIO && i == 0)) return i;
      end
      return -1;
   endfunction

   task automatic step(input logic rst, input logic [3:0] v, output int g, output logic [3:0] rdy);
      logic [3:0] exp_ready;
      @(negedge clk);
      reset         = rst;
      in_valid      = v;
      bus.src_valid = v;
      for (int i = 0; i < 4; i++) begin
         bus.src_tag[i*7 +: 7]    = in_tag[i];
         bus.src_rd[i*5 +: 5]     = in_rd[i];
         bus.src_data[i*32 +: 32] = in_data[i];
      end
      #1;
      g         = rst ? -1 : model_pick(v, m_ptr);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      rdy = bus.src_ready;
      check("src_ready", bus.src_ready, exp_ready);
      check("cdb_valid_mid", bus.cdb_valid, m_valid && !rst);
      check("rf_we_mid", bus.rf_we, m_valid && !rst && (m_res.rd != 0));
      @(posedge clk);
      if (rst) begin
         m_ptr   = 0;
         m_valid = 1'b0;
         m_res   = '0;
      end else if (g >= 0) begin
         if (!(PRIO && g == 0)) m_ptr = (g + 1) % 4;
         m_valid    = 1'b1;
         m_res.tag  = in_tag[g];
         m_res.rd   = in_rd[g];
         m_res.data = in_data[g];
      end else begin
         m_valid = 1'b0;
      end
      #1;
      check("cdb_valid", bus.cdb_valid, m_valid);
      check("cdb_tag", bus.cdb_tag, m_res.tag);
      check("cdb_data", bus.cdb_data, m_res.data);
      check("rf_wa", bus.rf_wa, m_res.rd);
      check("rf_wd", bus.rf_wd, m_res.data);
      check("rf_we", bus.rf_we, m_valid && (m_res.rd != 0));
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic [3:0] ready;
      logic       cv;
      logic [6:0] tag;
   } vec_t;

   vec_t        tbl[16];
   int          g;
   logic [3:0]  rdy;
   logic [3:0]  pend;
   logic        rrst;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      m_ptr         = 0;
      m_valid       = 1'b0;
      m_res         = '0;
      bus.src_valid = '0;
      bus.src_tag   = '0;
      bus.src_rd    = '0;
      bus.src_data  = '0;
      for (int i = 0; i < 4; i++) begin
         in_tag[i]  = 7'(8'h10 + i);
         in_rd[i]   = 5'(i + 1);
         in_data[i] = 32'hA000_0000 + i;
      end

      // Expected outputs are those visible after the cycle's clock edge.
      tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 7'h00};
      tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 7'h00};
      tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 7'h10};
      tbl[3]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 7'h11};
      tbl[4]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 7'h12};
      tbl[5]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 7'h13};
      tbl[6]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 7'h10};
      tbl[7]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 7'h11};
      tbl[8]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 7'h12};
      tbl[9]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 7'h13};
      tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 7'h00};
      tbl[11] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 7'h12};
      tbl[12] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 7'h12};
      tbl[13] = '{1'b0, 4'b1010, 4'b1000, 1'b1, 7'h13};
      tbl[14] = '{1'b0, 4'b1010, 4'b0010, 1'b1, 7'h11};
      tbl[15] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 7'h10};

`ifndef WB_LOAD_PRIO_EN
      for (int t = 0; t < 16; t++) begin
         step(tbl[t].rst, tbl[t].v, g, rdy);
         check($sformatf("tbl%0d_ready", t), rdy, tbl[t].ready);
         check($sformatf("tbl%0d_cdb_valid", t), bus.cdb_valid, tbl[t].cv);
         if (tbl[t].cv) check($sformatf("tbl%0d_cdb_tag", t), bus.cdb_tag, tbl[t].tag);
      end
`else
      step(1'b1, 4'b1111, g, rdy);
      step(1'b1, 4'b1111, g, rdy);
      check("prio_reset_ready", rdy, 4'b0000);
      for (int t = 0; t < 3; t++) begin
         step(1'b0, 4'b1001, g, rdy);
         check("prio_src0_ready", rdy, 4'b0001);
         check("prio_src0_tag", bus.cdb_tag, 7'h10);
      end
      step(1'b0, 4'b1000, g, rdy);
      check("prio_src3_ready", rdy, 4'b1000);
      check("prio_src3_tag", bus.cdb_tag, 7'h13);
`endif

      // Single source, back-to-back capable.
      in_tag[2]  = 7'h15;
      in_rd[2]   = 5'd7;
      in_data[2] = 32'hDEAD_BEEF;
      step(1'b0, 4'b0100, g, rdy);
      check("single_ready", rdy, 4'b0100);
      check("single_rf_we", bus.rf_we, 1'b1);
      check("single_rf_wa", bus.rf_wa, 5'd7);
      check("single_rf_wd", bus.rf_wd, 32'hDEAD_BEEF);
      check("single_cdb_tag", bus.cdb_tag, 7'h15);

      // Write to r0: broadcast but no RF write.
      in_tag[1]  = 7'h03;
      in_rd[1]   = 5'd0;
      in_data[1] = 32'h0000_1234;
      step(1'b0, 4'b0010, g, rdy);
      check("r0_cdb_valid", bus.cdb_valid, 1'b1);
      check("r0_cdb_tag", bus.cdb_tag, 7'h03);
      check("r0_rf_we", bus.rf_we, 1'b0);

      // Reset lands while tag 0x2A sits in the output register.
      in_tag[1] = 7'h2A;
      in_rd[1]  = 5'd9;
      step(1'b0, 4'b0010, g, rdy);
      check("mid_cdb_tag", bus.cdb_tag, 7'h2A);
      step(1'b1, 4'b1111, g, rdy);
      check("mid_rst_ready", rdy, 4'b0000);
      check("mid_rst_cdb_valid", bus.cdb_valid, 1'b0);
      check("mid_rst_rf_wa", bus.rf_wa, 5'd0);
      step(1'b0, 4'b1111, g, rdy);
      check("mid_post_ready", rdy, 4'b0001);

      // Randomized traffic; sources hold fields until granted.
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
               pend[i]    = 1'b1;
               in_tag[i]  = 7'($urandom);
               in_rd[i]   = 5'($urandom);
               in_data[i] = $urandom;
            end
         end
         rrst = ($urandom_range(39, 0) == 0);
         step(rrst, pend, g, rdy);
         if (g >= 0) pend[g] = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
